// File: rtl/pal_timing_generator.sv
// rtl/pal_timing_generator.sv - parametrised PAL sync generator, progressive/interlaced, half-line vsync
// Optional burst gate output enabled by defining PAL_BURST_GATE_EN.
module pal_timing_generator #(
  parameter int H_TOTAL     = 480,
  parameter int H_ACTIVE    = 390,
  parameter int H_FPORCH    = 12,
  parameter int H_SYNC      = 35,
  parameter int EQ_PULSE    = 18,
  parameter int BROAD_PULSE = 205,
  parameter int V_TOTAL     = 312,
  parameter int V_ACTIVE    = 288,
  parameter int VS_LINE     = 300,
  parameter int EQ_HL       = 5,
  parameter int BROAD_HL    = 5
`ifdef PAL_BURST_GATE_EN
  ,
  parameter int BURST_START = 5,
  parameter int BURST_LEN   = 17
`endif
) (
  input  logic       clk7,
  input  logic       rst_n,
  input  logic       interlace,
  input  logic       video_in,
  output logic [8:0] hc,
  output logic [8:0] vc,
  output logic       field,
  output logic       video_out,
  output logic       csync,
  output logic       hblank,
  output logic       vblank
`ifdef PAL_BURST_GATE_EN
  ,
  output logic       burst_gate
`endif
);

  localparam int H_HALF = H_TOTAL / 2;
  localparam int HS0    = H_ACTIVE + H_FPORCH;
  localparam int HS1    = (HS0 >= H_HALF) ? HS0 - H_HALF : HS0 + H_HALF;

  localparam logic [8:0] HS0_C  = 9'(HS0);
  localparam logic [8:0] HS1_C  = 9'(HS1);
  localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
  localparam logic [8:0] HA_C   = 9'(H_ACTIVE);
  localparam logic [8:0] VA_C   = 9'(V_ACTIVE);
  localparam logic [8:0] VS0_C  = 9'(VS_LINE);
  localparam logic [8:0] VS1_C  = 9'(VS_LINE + 1);
  localparam logic [8:0] VT_C   = 9'(V_TOTAL);
  localparam logic [8:0] VT1_C  = 9'(V_TOTAL - 1);
  localparam logic [8:0] W_HS   = 9'(H_SYNC);
  localparam logic [8:0] W_EQ   = 9'(EQ_PULSE);
  localparam logic [8:0] W_BR   = 9'(BROAD_PULSE);
  localparam logic [7:0] N_EQ   = 8'(EQ_HL);
  localparam logic [7:0] N_BR   = 8'(BROAD_HL);

  typedef enum logic [1:0] {NORMAL, PRE_EQ, BROAD, POST_EQ} sync_state_t;

  sync_state_t state, state_nx;
  logic [7:0]  hl_cnt, hl_nx;
  logic [8:0]  pcnt;
  logic [8:0]  pw;
  logic        ilace_q;
  logic        sync_pt, seq_start, field_end;

  // pw is the low width of a pulse starting at this sync point, 0 when none starts
  always_comb begin
    state_nx  = state;
    hl_nx     = hl_cnt;
    pw        = 9'd0;
    sync_pt   = (hc == HS0_C) || (hc == HS1_C);
    seq_start = (ilace_q && field) ? (hc == HS1_C && vc == VS1_C)
                                   : (hc == HS0_C && vc == VS0_C);
    field_end = (vc == ((ilace_q && !field) ? VT_C : VT1_C));
    if (sync_pt) begin
      case (state)
        NORMAL: begin
          if (seq_start) begin
            state_nx = PRE_EQ;
            hl_nx    = 8'd1;
            pw       = W_EQ;
          end else if (hc == HS0_C) begin
            pw = W_HS;
          end
        end
        PRE_EQ: begin
          if (hl_cnt == N_EQ) begin
            state_nx = BROAD;
            hl_nx    = 8'd1;
            pw       = W_BR;
          end else begin
            hl_nx = hl_cnt + 8'd1;
            pw    = W_EQ;
          end
        end
        BROAD: begin
          if (hl_cnt == N_BR) begin
            state_nx = POST_EQ;
            hl_nx    = 8'd1;
            pw       = W_EQ;
          end else begin
            hl_nx = hl_cnt + 8'd1;
            pw    = W_BR;
          end
        end
        default: begin
          if (hl_cnt == N_EQ) begin
            state_nx = NORMAL;
            hl_nx    = 8'd0;
            if (hc == HS0_C) pw = W_HS;
          end else begin
            hl_nx = hl_cnt + 8'd1;
            pw    = W_EQ;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk7) begin
    if (!rst_n) begin
      hc        <= 9'd0;
      vc        <= 9'd0;
      field     <= 1'b0;
      ilace_q   <= interlace;
      state     <= NORMAL;
      hl_cnt    <= 8'd0;
      pcnt      <= 9'd0;
      csync     <= 1'b1;
      hblank    <= 1'b0;
      vblank    <= 1'b0;
      video_out <= 1'b0;
    end else begin
      if (hc == H_LAST) begin
        hc <= 9'd0;
        if (field_end) begin
          vc <= 9'd0;
          if (ilace_q) field <= ~field;
          // mode can only change on the wrap that starts a new frame
          if (!ilace_q || field) ilace_q <= interlace;
        end else begin
          vc <= vc + 9'd1;
        end
      end else begin
        hc <= hc + 9'd1;
      end
      state  <= state_nx;
      hl_cnt <= hl_nx;
      if (pw != 9'd0) begin
        csync <= 1'b0;
        pcnt  <= pw - 9'd1;
      end else if (pcnt != 9'd0) begin
        csync <= 1'b0;
        pcnt  <= pcnt - 9'd1;
      end else begin
        csync <= 1'b1;
      end
      hblank    <= (hc >= HA_C);
      vblank    <= (vc >= VA_C);
      video_out <= video_in && (hc < HA_C) && (vc < VA_C);
    end
  end

`ifdef PAL_BURST_GATE_EN
  localparam logic [8:0] B0_C = 9'(HS0 + H_SYNC + BURST_START);
  localparam logic [8:0] B1_C = 9'(HS0 + H_SYNC + BURST_START + BURST_LEN);

  // a pulse is a normal hsync exactly when the FSM stays in (or returns to) NORMAL
  logic last_normal;

  always_ff @(posedge clk7) begin
    if (!rst_n) begin
      last_normal <= 1'b0;
      burst_gate  <= 1'b0;
    end else begin
      if (pw != 9'd0) last_normal <= (state_nx == NORMAL);
      burst_gate <= last_normal && (hc >= B0_C) && (hc < B1_C);
    end
  end
`endif

endmodule

// File: doc/pal_timing_generator.md
Name: pal_timing_generator

Overview:
- Parametrised successor to the fixed progressive PAL sync generator. Produces hc/vc counters, a field flag, registered composite sync, blanking and gated video.
- Timing values are parameters. Runtime selection between progressive (312-line fields) and true interlaced 625-line PAL.
- Vertical interval uses proper half-line equalising and broad (serrated) pulses.
- Sits between the pixel source and the DAC/RF modulator stage. Runs on the dot clock (7.5 MHz defaults).

Parameters:
- H_TOTAL, 480, dot clocks per line (must be even; H_HALF = H_TOTAL/2)
- H_ACTIVE, 390, active dots per line, starting at hc=0
- H_FPORCH, 12, dots from end of active to hsync start; HS0 = H_ACTIVE+H_FPORCH
- H_SYNC, 35, normal hsync low width
- EQ_PULSE, 18, equalising pulse low width
- BROAD_PULSE, 205, broad pulse low width (< H_HALF)
- V_TOTAL, 312, lines per progressive field / field 1; interlaced field 0 has V_TOTAL+1
- V_ACTIVE, 288, active lines per field, starting at vc=0
- VS_LINE, 300, line on which the vertical sequence starts
- EQ_HL, 5, half-lines in each of pre-eq and post-eq
- BROAD_HL, 5, half-lines of broad pulses

Ports:
- clk7  input  1  dot clock
- rst_n  input  1  reset, synchronous, active-low
- interlace  input  1  1 = interlaced 625, 0 = progressive 312; sampled only at frame start
- video_in  input  1  pixel for current (hc,vc)
- hc  output  9  horizontal counter
- vc  output  9  vertical counter within field
- field  output  1  current field (always 0 in progressive)
- video_out  output  1  gated video, registered
- csync  output  1  composite sync, active-low, registered
- hblank  output  1  hc >= H_ACTIVE, registered
- vblank  output  1  vc >= V_ACTIVE, registered

Behaviour:
- Reset (rst_n low at clk7 edge):
  - hc=0, vc=0, field=0, video_out=0, csync=1, hblank=0, vblank=0.
  - Sync FSM in NORMAL, half-line count 0.
  - interlace latch loaded from the interlace input.
  - Reset mid-line or mid-vsync aborts immediately. No partial pulse continues after reset.
- Counters:
  - hc wraps at H_TOTAL-1.
  - vc increments on hc wrap and wraps at field end: V_TOTAL-1, or V_TOTAL (313 lines) when the latch is 1 and field=0.
  - field toggles on vc wrap only when the latch is 1; otherwise it stays 0.
  - The latch reloads from the interlace input on the vc wrap that enters field 0. A change mid-frame has no effect until then.
- Half-line sync points: hc==HS0 and hc==HS0-H_HALF (mod H_TOTAL).
- Sync FSM states: NORMAL, PRE_EQ, BROAD, POST_EQ.
  - NORMAL -> PRE_EQ:
    - progressive, or field 0: at hc==HS0 on vc==VS_LINE
    - interlaced field 1: at hc==HS0-H_HALF on vc==VS_LINE+1 (half-line offset)
  - Each non-NORMAL state lasts its count of half-lines (EQ_HL, BROAD_HL, EQ_HL), counted at sync points.
  - POST_EQ -> NORMAL.
- csync low width, measured from the last sync point (in clocks):
  - NORMAL: H_SYNC, at HS0 only
  - PRE_EQ/POST_EQ: EQ_PULSE at every sync point
  - BROAD: BROAD_PULSE at every sync point
  - A pulse already running when the state changes completes with the width of the state in which it began.
- Output latency: csync, hblank, vblank and video_out reflect the (hc,vc) of the previous cycle, i.e. 1 clk latency.
  - video_out(t+1) = video_in(t) when (hc<H_ACTIVE && vc<V_ACTIVE) at t; else 0.
  - video_in must be aligned to hc/vc.
- Widths: all comparisons 9-bit unsigned. Modulo subtraction for the sync points is resolved at elaboration.

Optional Feature:
- Macro PAL_BURST_GATE_EN adds parameters BURST_START (default 5) and BURST_LEN (default 17), and output port burst_gate (1 bit, registered, reset 0).
- With the macro: burst_gate is high for BURST_LEN clocks, starting BURST_START clocks after the end of a NORMAL-state hsync. It is never asserted during PRE_EQ/BROAD/POST_EQ or on the lines they span.
- Without the macro: the port and logic are absent; all other behaviour is identical.

Test Plan:
- Progressive, defaults, 2 fields:
  - hc period 480 and vc period 312; field stays 0.
  - csync low 35 clk starting one clock after hc==402 on line 10.
- Progressive vsync, line 300:
  - 5 pulses of 18 clk, then 5 of 205 clk, then 5 of 18 clk, spaced 240 clk apart.
  - First pulse begins at hc 402 of vc 300; normal hsync resumes at hc 402 of vc 308.
- Interlaced (interlace=1 before frame start):
  - field 0 = 313 lines, field 1 = 312 lines, 625-line frame.
  - Field 1 sequence starts at hc 162 of vc 301, exactly 240 clk later than in field 0.
- interlace toggled 0->1 at vc 150 of field 0 -> no change until the next frame boundary; then field alternates.
- rst_n low for 1 clk at vc 303 mid-BROAD -> next cycle hc=0, vc=0, csync=1, video_out=0; the following vertical sequence occurs normally at vc 300.
- video_in held 1 -> video_out high exactly when the previous cycle's hc<390 && vc<288; otherwise 0.
- With PAL_BURST_GATE_EN: burst_gate high for 17 clk starting 5 clk after each normal hsync ends; 0 throughout the 15 vsync half-lines.
